// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous memory between two requesters.
//
// m0 (cpu) and m1 (loader/DMA) each drive a req/gnt handshake. An access is accepted on
// any clock edge where req & gnt are both high. Grants are round-robin, and a burst limit
// stops one master from starving the other. Reads return on the issuing master's
// rdata/rvalid. Write strobes go straight to the memory.
//
// Optional build macro MEM_ARB_FIXED_PRIO_EN:
//   m0 wins every tie and has no burst limit. m1 is still limited while m0 requests.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   mX_req/we/addr/wdata request from master X, held stable until accepted
//   mX_gnt              registered grant; acceptance is req & gnt at a clock edge
//   mX_rdata/mX_rvalid  read byte and one-cycle valid pulse, 3 cycles after acceptance
//   mem_raddr/mem_waddr memory read / write address
//   mem_write           one-cycle memory write strobe
//   mem_data_in         byte to memory
//   mem_data_out        byte from memory (sampled 2 edges after mem_raddr updates)
module mem_arbiter #(
  parameter int unsigned addr_width = 9,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [addr_width-1:0] m0_addr,
  input  logic [7:0]            m0_wdata,
  output logic                  m0_gnt,
  output logic [7:0]            m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [addr_width-1:0] m1_addr,
  input  logic [7:0]            m1_wdata,
  output logic                  m1_gnt,
  output logic [7:0]            m1_rdata,
  output logic                  m1_rvalid,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;     // id of the master accepted most recently
  logic [7:0]  burst_q, burst_d;   // accesses accepted during the current grant

  // Accepted-access selection; the FSM guarantees at most one grant.
  logic                  acc0, acc1, acc, acc_we;
  logic [addr_width-1:0] acc_addr;
  logic [7:0]            acc_wdata;
  logic [7:0]            burst_inc, burst_acc;
  logic                  limit_hit, limit0;

  assign acc0      = m0_req & m0_gnt;
  assign acc1      = m1_req & m1_gnt;
  assign acc       = acc0 | acc1;
  assign acc_we    = acc1 ? m1_we    : m0_we;
  assign acc_addr  = acc1 ? m1_addr  : m0_addr;
  assign acc_wdata = acc1 ? m1_wdata : m0_wdata;

  assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
  assign burst_acc = acc ? burst_inc : burst_q;
  // The limit is judged on the count including an access accepted on this edge, so the
  // grant drops right after the MAX_BURST-th access.
  assign limit_hit = (burst_acc >= MaxBurst);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign limit0 = 1'b0;
`else
  assign limit0 = limit_hit;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      burst_q <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          state_d = StGrant0;
`else
          state_d = last_q ? StGrant0 : StGrant1;
`endif
        end else if (m0_req) begin
          state_d = StGrant0;
        end else if (m1_req) begin
          state_d = StGrant1;
        end
      end
      StGrant0: if (!m0_req || (limit0 && m1_req)) state_d = StIdle;
      StGrant1: if (!m1_req || (limit_hit && m0_req)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d  = acc ? acc1 : last_q;
    burst_d = (state_d == StIdle) ? 8'd0 : burst_acc;
  end

  // Outputs decoded from the registered state.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    unique case (state_q)
      StGrant0: m0_gnt = 1'b1;
      StGrant1: m1_gnt = 1'b1;
      default: ;
    endcase
  end

  // Memory command registers and the two-stage read-tag pipeline.
  logic [addr_width-1:0] raddr_q, waddr_q;
  logic                  write_q;
  logic [7:0]            wdata_q;
  logic                  rd1_vld_q, rd1_id_q, rd2_vld_q, rd2_id_q;
  logic                  rvalid0_q, rvalid1_q;
  logic [7:0]            rdata0_q, rdata1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q   <= '0;
      waddr_q   <= '0;
      write_q   <= 1'b0;
      wdata_q   <= 8'd0;
      rd1_vld_q <= 1'b0;
      rd1_id_q  <= 1'b0;
      rd2_vld_q <= 1'b0;
      rd2_id_q  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 8'd0;
      rdata1_q  <= 8'd0;
    end else begin
      write_q <= acc & acc_we;
      if (acc && acc_we) begin
        waddr_q <= acc_addr;
        wdata_q <= acc_wdata;
      end
      if (acc && !acc_we) raddr_q <= acc_addr;
      rd1_vld_q <= acc & ~acc_we;
      rd1_id_q  <= acc1;
      rd2_vld_q <= rd1_vld_q;
      rd2_id_q  <= rd1_id_q;
      rvalid0_q <= rd2_vld_q & ~rd2_id_q;
      rvalid1_q <= rd2_vld_q & rd2_id_q;
      if (rd2_vld_q && !rd2_id_q) rdata0_q <= mem_data_out;
      if (rd2_vld_q && rd2_id_q)  rdata1_q <= mem_data_out;
    end
  end

  assign mem_raddr   = raddr_q;
  assign mem_waddr   = waddr_q;
  assign mem_write   = write_q;
  assign mem_data_in = wdata_q;
  assign m0_rvalid   = rvalid0_q;
  assign m1_rvalid   = rvalid1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected reads/writes, derived from
// a reference byte array that is updated in acceptance order. It also runs a
// synchronous-read memory model and a grant-order check under contention.
module tb_mem_arbiter;
  localparam int unsigned AW       = 9;
  localparam int unsigned MaxBurst = 4;
  localparam int unsigned NCont    = 16;
  localparam int unsigned NRand    = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic          req_a  [2];
  logic          we_a   [2];
  logic [AW-1:0] addr_a [2];
  logic [7:0]    wd_a   [2];

  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write;
  logic [7:0]    m0_rdata, m1_rdata, mem_data_in, mem_dout;
  logic [AW-1:0] mem_raddr, mem_waddr;

  mem_arbiter #(.addr_width(AW), .MAX_BURST(MaxBurst)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (req_a[0]),
    .m0_we        (we_a[0]),
    .m0_addr      (addr_a[0]),
    .m0_wdata     (wd_a[0]),
    .m0_gnt       (m0_gnt),
    .m0_rdata     (m0_rdata),
    .m0_rvalid    (m0_rvalid),
    .m1_req       (req_a[1]),
    .m1_we        (we_a[1]),
    .m1_addr      (addr_a[1]),
    .m1_wdata     (wd_a[1]),
    .m1_gnt       (m1_gnt),
    .m1_rdata     (m1_rdata),
    .m1_rvalid    (m1_rvalid),
    .mem_raddr    (mem_raddr),
    .mem_waddr    (mem_waddr),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'hA7;
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Memory instance model: registered read, written by the one-cycle strobe.
  logic       mem_load = 1'b1;
  logic [7:0] phys_mem [512];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) phys_mem[i] <= init_val(i);
    end else if (mem_write) begin
      phys_mem[mem_waddr] <= mem_data_in;
    end
    mem_dout <= phys_mem[mem_raddr];
  end

  // Reference model: memory contents as seen in acceptance order.
  logic [7:0] ref_mem [512];

  typedef struct { int id; logic [7:0] data; int cyc; } rd_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int id; int cyc; } acc_t;
  rd_t  rd_exp [$];
  wr_t  wr_exp [$];
  acc_t acc_log[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic gnt_of(input int id);
    return (id != 0) ? m1_gnt : m0_gnt;
  endfunction

  // Called at the falling edge before the accepting rising edge.
  task automatic record(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [7:0] wd);
    rd_t  r;
    wr_t  w;
    acc_t a;
    if (we) begin
      ref_mem[addr] = wd;
      w.addr = addr;
      w.data = wd;
      wr_exp.push_back(w);
    end else begin
      r.id   = id;
      r.data = ref_mem[addr];
      r.cyc  = cyc + 3;
      rd_exp.push_back(r);
    end
    a.id  = id;
    a.cyc = cyc;
    acc_log.push_back(a);
  endtask

  // Entered #1 after a rising edge; returns #1 after the accepting edge.
  task automatic access(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [7:0] wd, input logic keep, output int waits);
    req_a[id]  = 1'b1;
    we_a[id]   = we;
    addr_a[id] = addr;
    wd_a[id]   = wd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (gnt_of(id)) break;
      waits++;
      if (waits > 300) break;
    end
    if (waits > 300) begin
      chk("gnt_timeout", 32'(waits), 32'd300);
      req_a[id] = 1'b0;
    end else begin
      record(id, we, addr, wd);
      @(posedge clk);
      #1;
      if (!keep) req_a[id] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a[0] = 1'b0;
    req_a[1] = 1'b0;
    @(posedge clk);
    #1;
    rd_exp.delete();
    wr_exp.delete();
    @(negedge clk);
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'({mem_raddr, mem_waddr}), 32'd0);
    chk("rst_data", 32'({mem_data_in, m0_rdata, m1_rdata}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rd_exp.size() != 0 || wr_exp.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(rd_exp.size() + wr_exp.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, plus protocol checks.
  logic pend [2];
  always @(negedge clk) begin : mon
    rd_t e;
    wr_t w;
    if (reset) begin
      pend[0] <= 1'b0;
      pend[1] <= 1'b0;
    end else begin
      chk("gnt_overlap", 32'(m0_gnt & m1_gnt), 32'd0);
      if (m0_rvalid || m1_rvalid) begin
        chk("rvalid_both", 32'(m0_rvalid & m1_rvalid), 32'd0);
        if (rd_exp.size() == 0) begin
          chk("spurious_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
        end else begin
          e = rd_exp.pop_front();
          chk("rd_master", 32'(m1_rvalid), 32'(e.id));
          chk("rd_data", 32'(m1_rvalid ? m1_rdata : m0_rdata), 32'(e.data));
          chk("rd_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_write) begin
        if (wr_exp.size() == 0) begin
          chk("spurious_write", 32'(mem_write), 32'd0);
        end else begin
          w = wr_exp.pop_front();
          chk("wr_addr", 32'(mem_waddr), 32'(w.addr));
          chk("wr_data", 32'(mem_data_in), 32'(w.data));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && !req_a[i]) chk("req_held", 32'(req_a[i]), 32'd1);
        pend[i] <= req_a[i] && !gnt_of(i);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Contention master: back-to-back random accesses, req never drops between them.
  task automatic cont_master(input int id);
    int w;
    for (int k = 0; k < int'(NCont); k++)
      access(id, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), 8'($urandom),
             k < int'(NCont) - 1, w);
  endtask

  task automatic rand_master(input int id);
    int w;
    int gap;
    for (int k = 0; k < int'(NRand); k++) begin
      gap = (k == int'(NRand) - 1) ? 1 : int'($urandom_range(0, 3));
      access(id, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
             8'($urandom), gap == 0, w);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin : main
    int w;
    int exp_id, prev_id, exp_gap;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; wd_a[i] = 8'd0;
    end
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    do_reset();
    mem_load = 1'b0;

    // m0 reads 0x005 from idle.
    access(0, 1'b0, 9'h005, 8'h00, 1'b0, w);
    chk("m0_gnt_latency", 32'(w), 32'd1);
    drain();
    chk("m0_rdata_005", 32'(m0_rdata), 32'hA7);

    // m1 writes 0x3C to 0x1FF, then m0 reads it back.
    access(1, 1'b1, 9'h1FF, 8'h3C, 1'b0, w);
    chk("m1_gnt_latency", 32'(w), 32'd1);
    access(0, 1'b0, 9'h1FF, 8'h00, 1'b0, w);
    drain();
    chk("m0_rdata_1ff", 32'(m0_rdata), 32'h3C);

    // Three back-to-back m0 reads while m1 waits for the grant.
    fork
      begin
        access(0, 1'b0, 9'h010, 8'h00, 1'b1, w);
        access(0, 1'b0, 9'h011, 8'h00, 1'b1, w);
        access(0, 1'b0, 9'h012, 8'h00, 1'b0, w);
      end
      begin
        @(posedge clk);
        #1;
        access(1, 1'b0, 9'h030, 8'h00, 1'b0, w);
      end
    join
    drain();

    // Both masters request continuously from reset.
    do_reset();
    acc_log.delete();
    fork
      cont_master(0);
      cont_master(1);
    join
    drain();
    chk("cont_count", 32'(acc_log.size()), 32'(2 * NCont));
    prev_id = 0;
    for (int i = 0; i < acc_log.size() && i < int'(2 * NCont); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_id = (i < int'(NCont)) ? 0 : 1;
      exp_gap = (exp_id == prev_id) ? 1 : 3;
`else
      exp_id = (i / int'(MaxBurst)) % 2;
      exp_gap = (exp_id == prev_id) ? 1 : 2;
`endif
      chk("burst_order", 32'(acc_log[i].id), 32'(exp_id));
      if (i > 0) chk("burst_gap", 32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'(exp_gap));
      prev_id = exp_id;
    end

    // Reset while an m1 read is in flight and its write strobe is pending.
    access(1, 1'b0, 9'h020, 8'h00, 1'b1, w);
    access(1, 1'b1, 9'h021, 8'h55, 1'b0, w);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      chk("post_rst_idle", 32'({m0_gnt, m1_gnt}), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic from both masters.
    fork
      rand_master(0);
      rand_master(1);
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide SoC memory between two requesters: m0 (cpu) and m1 (serial loader/monitor or DMA).
- Uses a registered req/gnt handshake on each side, round-robin arbitration and a burst limit to prevent starvation.
- Drives the memory's mem_raddr/mem_waddr/mem_write/mem_data_in and returns read data tagged to the issuing master.
- Sits between the requesters and the memory instance in the top level.

Parameters:
- addr_width, 9, width of all byte addresses.
- MAX_BURST, 16, maximum accepted accesses per grant while the other master is requesting; range 1..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- m0_req  input  1  m0 access request, held with m0_we/m0_addr/m0_wdata stable until accepted
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  addr_width  byte address
- m0_wdata  input  8  write byte
- m0_gnt  output  1  registered; access is accepted on any edge where m0_req & m0_gnt
- m0_rdata  output  8  read byte
- m0_rvalid  output  1  one-cycle pulse, m0_rdata valid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: identical to the m0 ports, for m1
- mem_raddr  output  addr_width  memory read address
- mem_waddr  output  addr_width  memory write address
- mem_write  output  1  memory write strobe, single cycle
- mem_data_in  output  8  byte to memory
- mem_data_out  input  8  byte from memory, valid 2 cycles after mem_raddr is registered

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - state=IDLE, last=1 (so m0 wins the first tie), burst count=0.
  - gnt, rvalid and mem_write all 0.
  - mem_raddr, mem_waddr, mem_data_in, m0_rdata and m1_rdata all 0.
- States:
  - IDLE: no grant.
    - Only one req high: go to that master's GRANT.
    - Both high: go to GRANT of the master that is not `last`.
    - Neither: stay.
  - GRANT0 / GRANT1: the corresponding gnt is 1 in this state, registered so it is visible the cycle after entry.
- Accept on edge E when req & gnt:
  - Read: mem_raddr<=addr; push a tag with the master id into a 2-stage read pipeline.
  - Write: mem_waddr<=addr, mem_data_in<=wdata, mem_write<=1 for exactly one cycle.
  - burst count increments, saturating at 255; `last` <= this master.
- Read return:
  - At edge E+2, rdata of the tagged master <= mem_data_out.
  - rvalid of the tagged master is 1 for the cycle after E+2, i.e. 3 cycles after the request cycle.
  - Back-to-back reads give back-to-back rvalid pulses in order.
- Leaving a GRANT state: the grant is released (next state IDLE, gnt=0 next cycle, burst count cleared) when either:
  - the granted req is low, or
  - burst count reaches MAX_BURST while the other master's req is high.
- Without contention there is no burst limit: a lone master keeps its grant indefinitely.
- Handover costs exactly one IDLE cycle. In-flight reads still complete to the original master after the switch.
- Same-address write from one master and read from the other in consecutive cycles: memory order applies, no forwarding.
- Simultaneous req rise from both masters in IDLE: round-robin via `last`.
- req dropping on the same edge it is accepted: that access counts, then the grant is released.
- Reset mid-operation:
  - Pending reads are discarded; no rvalid follows reset.
  - An in-flight mem_write is cleared on the reset edge.
- A master must not drop req before acceptance; a bench assertion flags it.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined:
  - m0 always wins ties in IDLE.
  - The MAX_BURST limit does not apply to m0; m0 keeps its grant while m0_req is high.
  - m1's burst limit still applies when m0 requests.
- Undefined: round-robin with MAX_BURST fairness, as described above.

Test Plan:
- Reset, then m0 reads address 0x005 holding 0xA7:
  - m0_gnt=1 the cycle after req.
  - m0_rvalid pulses with m0_rdata=0xA7, 3 cycles after the accept edge.
  - m1_rvalid stays 0.
- m1 writes 0x3C to 0x1FF:
  - mem_write is a single-cycle pulse with mem_waddr=0x1FF, mem_data_in=0x3C.
  - A later m0 read of 0x1FF returns 0x3C.
- Both masters request continuously from reset, MAX_BURST=4:
  - m0 accepted 4 times, 1 IDLE cycle, m1 accepted 4 times, and so on.
  - No grant overlap, ever.
- m0 issues 3 back-to-back reads of 0x010..0x012, then m1 takes the grant:
  - Three consecutive m0_rvalid pulses with the correct bytes.
  - None of the data goes to m1.
- Assert reset while one read is in flight and m1 is granted:
  - No rvalid afterwards; gnt=0 and mem_write=0 the cycle after.
  - With no requester active, state returns to IDLE.
- With MEM_ARB_FIXED_PRIO_EN, both masters request for 40 cycles:
  - Only m0_gnt is asserted.
  - m1 is granted within 2 cycles of m0_req falling.
